// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA 640x480@60 default timing constants, position
// type, decoded-output bundle and a window-test helper. Used by vga_timing
// and by any downstream pixel-source stage that must agree on the geometry.
package vga_timing_pkg;

  // Default clk cycles per pixel.
  localparam int CLK_DIV      = 32'd2;

  // Horizontal timing in pixels.
  localparam int H_VISIBLE    = 32'd640;
  localparam int H_FRONT      = 32'd16;
  localparam int H_SYNC       = 32'd96;
  localparam int H_BACK       = 32'd48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing in lines.
  localparam int V_VISIBLE    = 32'd480;
  localparam int V_FRONT      = 32'd10;
  localparam int V_SYNC       = 32'd2;
  localparam int V_BACK       = 32'd33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // All position arithmetic is 16 bits wide.
  typedef logic [15:0] pos_t;

  // Registered decode of the position; sync bits are active low.
  typedef struct packed {
    logic enable;
    logic hsync;
    logic vsync;
  } vga_decode_t;

  // True when lo <= pos < hi.
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_mod_counter.sv
// mod_counter: modulo-N counter with count enable.
//   clk_i     : clock, rising edge
//   reset_i   : synchronous active-high reset, loads RESET_VAL
//   en_i      : advance by one (wrapping MODULUS-1 -> 0) on this edge
//   count_o   : registered count, 0..MODULUS-1
//   wrap_o    : combinational, high when en_i is high and count is MODULUS-1
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter pos_t MODULUS   = 16'd2,
  parameter pos_t RESET_VAL = 16'd0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output pos_t count_o,
  output logic wrap_o
);

  pos_t count_q;
  pos_t count_d;
  logic at_max_s;

  assign at_max_s = (count_q == (MODULUS - 16'd1));

  // Next-state count: hold, increment, or wrap to zero.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (at_max_s) begin
        count_d = 16'd0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset load.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = en_i & at_max_s;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset; parks position at the last
//                 pixel of the frame so the first tick enters (0,0)
//   pixel_tick  : one clk per pixel period (combinational from the divider)
//   column, row : current position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   enable      : position is in the visible area
//   hsync,vsync : active-low sync pulses
//   frame_start : one-clk pulse in the clk after (0,0) is loaded
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pixel_tick,
  output logic [15:0] column,
  output logic [15:0] row,
  output logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam pos_t DIV_P          = pos_t'(CLK_DIV);
  localparam pos_t H_VIS_P        = pos_t'(H_VISIBLE);
  localparam pos_t H_TOTAL_P      = pos_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam pos_t H_SYNC_START_P = pos_t'(H_VISIBLE + H_FRONT);
  localparam pos_t H_SYNC_END_P   = pos_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam pos_t V_VIS_P        = pos_t'(V_VISIBLE);
  localparam pos_t V_TOTAL_P      = pos_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam pos_t V_SYNC_START_P = pos_t'(V_VISIBLE + V_FRONT);
  localparam pos_t V_SYNC_END_P   = pos_t'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam vga_decode_t DEC_RESET = '{enable: 1'b0, hsync: 1'b1, vsync: 1'b1};

  pos_t        div_cnt_s;
  logic        div_wrap_s;
  logic        pixel_tick_s;
  pos_t        col_s;
  logic        col_wrap_s;
  pos_t        row_s;
  logic        row_wrap_s;
  pos_t        col_next_s;
  pos_t        row_next_s;
  vga_decode_t dec_d;
  vga_decode_t dec_q;
  logic        frame_start_d;
  logic        frame_start_q;

  mod_counter #(
    .MODULUS  (DIV_P),
    .RESET_VAL(16'd0)
  ) u_div (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (1'b1),
    .count_o(div_cnt_s),
    .wrap_o (div_wrap_s)
  );

  assign pixel_tick_s = (div_cnt_s == (DIV_P - 16'd1));

  // div_wrap_s equals pixel_tick_s because the divider is always enabled.
  mod_counter #(
    .MODULUS  (H_TOTAL_P),
    .RESET_VAL(H_TOTAL_P - 16'd1)
  ) u_col (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (div_wrap_s),
    .count_o(col_s),
    .wrap_o (col_wrap_s)
  );

  mod_counter #(
    .MODULUS  (V_TOTAL_P),
    .RESET_VAL(V_TOTAL_P - 16'd1)
  ) u_row (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (col_wrap_s),
    .count_o(row_s),
    .wrap_o (row_wrap_s)
  );

  // Position after the next tick, decoded so outputs line up with row/column.
  always_comb begin
    col_next_s = col_s + 16'd1;
    row_next_s = row_s;
    if (col_wrap_s) begin
      col_next_s = 16'd0;
      if (row_wrap_s) begin
        row_next_s = 16'd0;
      end else begin
        row_next_s = row_s + 16'd1;
      end
    end else begin
      col_next_s = col_s + 16'd1;
      row_next_s = row_s;
    end
    dec_d.enable  = (col_next_s < H_VIS_P) && (row_next_s < V_VIS_P);
    dec_d.hsync   = ~in_window(col_next_s, H_SYNC_START_P, H_SYNC_END_P);
    dec_d.vsync   = ~in_window(row_next_s, V_SYNC_START_P, V_SYNC_END_P);
    // Row wraps only when leaving the last pixel of the frame, i.e. entering (0,0).
    frame_start_d = row_wrap_s;
  end

  // Decoded outputs: load on pixel ticks, hold otherwise; frame_start pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q         <= DEC_RESET;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (pixel_tick_s) begin
        dec_q <= dec_d;
      end else begin
        dec_q <= dec_q;
      end
    end
  end

  assign pixel_tick  = pixel_tick_s;
  assign column      = col_s;
  assign row         = row_s;
  assign enable      = dec_q.enable;
  assign hsync       = dec_q.hsync;
  assign vsync       = dec_q.vsync;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing. Three instances: default 640x480 timing with
// CLK_DIV=2 (reset, first pixel, full line), a reduced 8x6 geometry with
// CLK_DIV=2 (full frames, mid-frame reset) and the same reduced geometry
// with CLK_DIV=1. Expectations are queued as stimulus is applied and
// compared against observations as the DUT produces them.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_s, rst_o;
  logic        pt_d, en_d, hs_d, vs_d, fs_d;
  logic [15:0] col_d, row_d;
  logic        pt_s, en_s, hs_s, vs_s, fs_s;
  logic [15:0] col_s, row_s;
  logic        pt_o, en_o, hs_o, vs_o, fs_o;
  logic [15:0] col_o, row_o;

  vga_timing dut_d (
    .clk(clk), .reset(rst_d), .pixel_tick(pt_d), .column(col_d), .row(row_d),
    .enable(en_d), .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d)
  );

  // Small geometry: H_TOTAL=15, hsync [10,13); V_TOTAL=10, vsync [7,9).
  vga_timing #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pixel_tick(pt_s), .column(col_s), .row(row_s),
    .enable(en_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s)
  );

  vga_timing #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_o (
    .clk(clk), .reset(rst_o), .pixel_tick(pt_o), .column(col_o), .row(row_o),
    .enable(en_o), .hsync(hs_o), .vsync(vs_o), .frame_start(fs_o)
  );

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Advance n clocks; inputs are driven and outputs sampled at the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    rst_d = 1'b1; rst_s = 1'b1; rst_o = 1'b1;
    step(3);
    exp_q.push_back('{"rst_col", 32'd799});  obs_q.push_back(32'(col_d));
    exp_q.push_back('{"rst_row", 32'd524});  obs_q.push_back(32'(row_d));
    exp_q.push_back('{"rst_en", 32'd0});     obs_q.push_back(32'(en_d));
    exp_q.push_back('{"rst_hs", 32'd1});     obs_q.push_back(32'(hs_d));
    exp_q.push_back('{"rst_vs", 32'd1});     obs_q.push_back(32'(vs_d));
    exp_q.push_back('{"rst_fs", 32'd0});     obs_q.push_back(32'(fs_d));
    exp_q.push_back('{"rst_pt", 32'd0});     obs_q.push_back(32'(pt_d));
    exp_q.push_back('{"rst_s_col", 32'd14}); obs_q.push_back(32'(col_s));
    exp_q.push_back('{"rst_s_row", 32'd9});  obs_q.push_back(32'(row_s));
    exp_q.push_back('{"rst_o_pt", 32'd1});   obs_q.push_back(32'(pt_o));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  task automatic test_first_pixel();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    rst_d = 1'b0;
    exp_q.push_back('{"t1_pt", 32'd1});    exp_q.push_back('{"t1_col", 32'd799});
    exp_q.push_back('{"t1_row", 32'd524}); exp_q.push_back('{"t1_en", 32'd0});
    exp_q.push_back('{"t2_col", 32'd0});   exp_q.push_back('{"t2_row", 32'd0});
    exp_q.push_back('{"t2_en", 32'd1});    exp_q.push_back('{"t2_fs", 32'd1});
    exp_q.push_back('{"t2_hs", 32'd1});    exp_q.push_back('{"t2_vs", 32'd1});
    exp_q.push_back('{"t2_pt", 32'd0});
    exp_q.push_back('{"t3_fs", 32'd0});    exp_q.push_back('{"t3_pt", 32'd1});
    exp_q.push_back('{"t3_col", 32'd0});
    step(1);
    obs_q.push_back(32'(pt_d)); obs_q.push_back(32'(col_d));
    obs_q.push_back(32'(row_d)); obs_q.push_back(32'(en_d));
    step(1);
    obs_q.push_back(32'(col_d)); obs_q.push_back(32'(row_d));
    obs_q.push_back(32'(en_d)); obs_q.push_back(32'(fs_d));
    obs_q.push_back(32'(hs_d)); obs_q.push_back(32'(vs_d));
    obs_q.push_back(32'(pt_d));
    step(1);
    obs_q.push_back(32'(fs_d)); obs_q.push_back(32'(pt_d));
    obs_q.push_back(32'(col_d));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  // Runs one full line of dut_d starting at column 0 of row 0.
  task automatic test_line();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    int low_ticks = 0, en_ticks = 0, first_low = -1, last_low = -1;
    int wrap_col = -1, wrap_row = -1;
    bit wrapped = 1'b0;
    exp_q.push_back('{"line_wrapped", 32'd1});
    exp_q.push_back('{"hs_low_ticks", 32'd96});
    exp_q.push_back('{"hs_first_low_col", 32'd656});
    exp_q.push_back('{"hs_last_low_col", 32'd751});
    exp_q.push_back('{"line_en_ticks", 32'd640});
    exp_q.push_back('{"wrap_col", 32'd0});
    exp_q.push_back('{"wrap_row", 32'd1});
    for (int c = 0; c < 2000 && !wrapped; c++) begin
      if (pt_d === 1'b1) begin
        if (en_d === 1'b1) en_ticks++;
        if (hs_d === 1'b0) begin
          low_ticks++;
          if (first_low < 0) first_low = int'(col_d);
          last_low = int'(col_d);
        end
        if (col_d == 16'd799) begin
          step(1);
          wrap_col = int'(col_d);
          wrap_row = int'(row_d);
          wrapped  = 1'b1;
        end
      end
      if (!wrapped) step(1);
    end
    obs_q.push_back(32'(wrapped));
    obs_q.push_back(32'(low_ticks)); obs_q.push_back(32'(first_low));
    obs_q.push_back(32'(last_low));  obs_q.push_back(32'(en_ticks));
    obs_q.push_back(32'(wrap_col));  obs_q.push_back(32'(wrap_row));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  // Two back-to-back frames on the small geometry: 2*15*10 = 300 clks each.
  task automatic test_frame();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    int pulse[3];
    int npulse = 0, en_ticks = 0, vs_ticks = 0, hs_ticks = 0, fs_samples = 0;
    pulse[0] = -1; pulse[1] = -1; pulse[2] = -1;
    rst_s = 1'b0;
    exp_q.push_back('{"frame_first_pulse", 32'd2});
    exp_q.push_back('{"frame_period_1", 32'd300});
    exp_q.push_back('{"frame_period_2", 32'd300});
    exp_q.push_back('{"frame_en_ticks", 32'd48});
    exp_q.push_back('{"frame_vs_ticks", 32'd30});
    exp_q.push_back('{"frame_hs_ticks", 32'd30});
    exp_q.push_back('{"frame_fs_samples", 32'd1});
    for (int c = 1; c <= 1000 && npulse < 3; c++) begin
      step(1);
      if (fs_s === 1'b1) begin
        pulse[npulse] = c;
        npulse++;
      end
      if (npulse == 1) begin
        if (fs_s === 1'b1) fs_samples++;
        if (pt_s === 1'b1 && en_s === 1'b1) en_ticks++;
        if (pt_s === 1'b1 && vs_s === 1'b0) vs_ticks++;
        if (pt_s === 1'b1 && hs_s === 1'b0) hs_ticks++;
      end
    end
    obs_q.push_back(32'(pulse[0]));
    obs_q.push_back((pulse[1] < 0) ? 32'hFFFF_FFFF : 32'(pulse[1] - pulse[0]));
    obs_q.push_back((pulse[2] < 0) ? 32'hFFFF_FFFF : 32'(pulse[2] - pulse[1]));
    obs_q.push_back(32'(en_ticks)); obs_q.push_back(32'(vs_ticks));
    obs_q.push_back(32'(hs_ticks)); obs_q.push_back(32'(fs_samples));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  // Reset on a tick edge while both syncs are low (row 7, column 11).
  task automatic test_midframe_reset();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    bit found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (row_s == 16'd7 && col_s == 16'd11 && pt_s === 1'b1) found = 1'b1;
      else step(1);
    end
    exp_q.push_back('{"mid_found", 32'd1});
    exp_q.push_back('{"mid_pre_hs", 32'd0}); exp_q.push_back('{"mid_pre_vs", 32'd0});
    obs_q.push_back(32'(found));
    obs_q.push_back(32'(hs_s)); obs_q.push_back(32'(vs_s));
    rst_s = 1'b1;
    exp_q.push_back('{"mid_rst_col", 32'd14}); exp_q.push_back('{"mid_rst_row", 32'd9});
    exp_q.push_back('{"mid_rst_en", 32'd0});   exp_q.push_back('{"mid_rst_hs", 32'd1});
    exp_q.push_back('{"mid_rst_vs", 32'd1});   exp_q.push_back('{"mid_rst_fs", 32'd0});
    step(1);
    obs_q.push_back(32'(col_s)); obs_q.push_back(32'(row_s));
    obs_q.push_back(32'(en_s));  obs_q.push_back(32'(hs_s));
    obs_q.push_back(32'(vs_s));  obs_q.push_back(32'(fs_s));
    rst_s = 1'b0;
    exp_q.push_back('{"mid_r1_pt", 32'd1});  exp_q.push_back('{"mid_r1_col", 32'd14});
    exp_q.push_back('{"mid_r2_col", 32'd0}); exp_q.push_back('{"mid_r2_row", 32'd0});
    exp_q.push_back('{"mid_r2_en", 32'd1});  exp_q.push_back('{"mid_r2_fs", 32'd1});
    step(1);
    obs_q.push_back(32'(pt_s)); obs_q.push_back(32'(col_s));
    step(1);
    obs_q.push_back(32'(col_s)); obs_q.push_back(32'(row_s));
    obs_q.push_back(32'(en_s));  obs_q.push_back(32'(fs_s));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  // CLK_DIV=1: tick every clk; last visible pixel (5,7) -> column 8, enable 0.
  task automatic test_clkdiv1();
    logic [31:0] obs_q[$];
    exp_t e;
    logic [31:0] o;
    int pt_low = 0;
    bit found = 1'b0;
    rst_o = 1'b0;
    exp_q.push_back('{"d1_first_col", 32'd0}); exp_q.push_back('{"d1_first_row", 32'd0});
    exp_q.push_back('{"d1_first_fs", 32'd1});
    exp_q.push_back('{"d1_second_col", 32'd1}); exp_q.push_back('{"d1_second_fs", 32'd0});
    step(1);
    obs_q.push_back(32'(col_o)); obs_q.push_back(32'(row_o)); obs_q.push_back(32'(fs_o));
    step(1);
    obs_q.push_back(32'(col_o)); obs_q.push_back(32'(fs_o));
    exp_q.push_back('{"d1_found", 32'd1});   exp_q.push_back('{"d1_last_vis_en", 32'd1});
    exp_q.push_back('{"d1_next_col", 32'd8}); exp_q.push_back('{"d1_next_row", 32'd5});
    exp_q.push_back('{"d1_next_en", 32'd0});  exp_q.push_back('{"d1_pt_low", 32'd0});
    for (int c = 0; c < 200 && !found; c++) begin
      if (pt_o !== 1'b1) pt_low++;
      if (row_o == 16'd5 && col_o == 16'd7) found = 1'b1;
      else step(1);
    end
    obs_q.push_back(32'(found)); obs_q.push_back(32'(en_o));
    step(1);
    if (pt_o !== 1'b1) pt_low++;
    obs_q.push_back(32'(col_o)); obs_q.push_back(32'(row_o));
    obs_q.push_back(32'(en_o));  obs_q.push_back(32'(pt_low));
    while (obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.value) begin
        errors++;
        $display("FAIL %s: observed %0d required %0d", e.tag, o, e.value);
      end
    end
  endtask

  initial begin
    rst_d = 1'b1; rst_s = 1'b1; rst_o = 1'b1;
    test_reset();
    test_first_pixel();
    test_line();
    test_frame();
    test_midframe_reset();
    test_clkdiv1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per pixel (legal range 1..16).
REQ-002 SHALL have parameters H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal timing in pixels.
REQ-003 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33: vertical timing in lines.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port pixel_tick, output, 1: high for one clk per pixel period.
REQ-007 SHALL have port column, output, 16: current horizontal position, 0..H_TOTAL-1.
REQ-008 SHALL have port row, output, 16: current vertical position, 0..V_TOTAL-1.
REQ-009 SHALL have port enable, output, 1: high while the position is inside the visible area.
REQ-010 SHALL have port hsync, output, 1: horizontal sync, active low.
REQ-011 SHALL have port vsync, output, 1: vertical sync, active low.
REQ-012 SHALL have port frame_start, output, 1: one-clk pulse at entry to position (0,0).

Function
REQ-013 SHALL define H_TOTAL = sum of the H_* parameters (800) and V_TOTAL = sum of the V_* parameters (525).
REQ-014 SHALL use a divider count that runs 0..CLK_DIV-1 and wraps to 0.
REQ-015 SHALL assert pixel_tick combinationally while divider count == CLK_DIV-1; with CLK_DIV=1, pixel_tick is high every clk.
REQ-016 SHALL advance column by 1 on each clk edge where pixel_tick is high; at column == H_TOTAL-1 it SHALL wrap to 0 instead.
REQ-017 SHALL advance row by 1 only on the edge where column wraps; at row == V_TOTAL-1 it SHALL wrap to 0 on that same edge.
REQ-018 SHALL hold column, row and all decoded outputs constant on edges where pixel_tick is low.
REQ-019 SHALL register enable, hsync and vsync from the next-state position, with zero skew to row/column.
REQ-020 SHALL set enable = (column < H_VISIBLE) and (row < V_VISIBLE).
REQ-021 SHALL drive hsync low for column in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752), and high otherwise.
REQ-022 SHALL drive vsync low for row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492), and high otherwise, for the whole line.
REQ-023 SHALL assert frame_start, registered, for exactly one clk: the clk after the edge that loads (0,0).
REQ-024 SHALL perform all arithmetic at 16-bit width, with no overflow for legal parameters.

Reset
REQ-025 SHALL apply, while reset is high at a clk edge: divider=0, column=H_TOTAL-1, row=V_TOTAL-1, enable=0, hsync=1, vsync=1, frame_start=0.
REQ-026 SHALL therefore move to (0,0) with enable=1 and frame_start=1 on the first pixel_tick after reset release.
REQ-027 SHALL give reset priority over pixel_tick when both occur on the same edge, including a reset asserted mid-frame.

Structure
REQ-028 SHALL place the default timing constants (H_*, V_*, H_TOTAL, V_TOTAL, sync start/end) in shared package vga_timing_pkg, for use by vga_timing and downstream pixel-source stages.
REQ-029 SHALL implement the divider, column counter and row counter as three instances of one sub-module, mod_counter, with parameterised modulus, count-enable input, wrap output and synchronous reset load value.

Verification
REQ-030 SHALL check: CLK_DIV=2, reset released at cycle 0 -> pixel_tick high at cycle 1; after that edge row=0, column=0, enable=1, frame_start=1 for one clk.
REQ-031 SHALL check: a full line -> hsync low for exactly 96 ticks starting at column 656; column wraps 799->0 and row increments in the same edge.
REQ-032 SHALL check: a full frame -> consecutive frame_start pulses are 840000 clks apart; enable high for 307200 ticks; vsync low for 1600 ticks (rows 490-491).
REQ-033 SHALL check: reset asserted at row=200, column=300 -> next clk shows column=799, row=524, enable=0, hsync=1, vsync=1; restart as in REQ-030.
REQ-034 SHALL check: CLK_DIV=1 -> pixel_tick constantly high; row=479, column=639 -> next edge column=640, enable=0.
REQ-035 SHALL check: position 524/799 -> next tick gives 0/0, frame_start=1, vsync=1, hsync=1.
